// File: rtl/multdiv_issue_ctrl.sv
// rtl/multdiv_issue_ctrl.sv - issue/handshake controller for the multi-cycle multiply/divide units
//
// Accepts one mult/div instruction from the execute stage, stalls the pipeline,
// pulses the selected unit's start strobe, waits for its ready (bounded by
// TIMEOUT cycles) and presents a one-cycle writeback.
//
// Ports:
//   clock, reset                    clock and asynchronous active-high reset
//   issue_valid, issue_is_div       instruction present / 1 = divide, 0 = multiply
//   issue_opA, issue_opB, issue_rd  signed operands and destination register
//   stall                           holds the upstream pipeline
//   ctrl_MULT, ctrl_DIV             one-cycle start strobes to the units
//   md_operandA, md_operandB        operands latched at accept, stable until next accept
//   mult_resultRDY/_exception/_result, div_resultRDY/_exception/_result  unit outputs
//   wb_valid, wb_rd, wb_data, wb_exception  one-cycle writeback
module multdiv_issue_ctrl #(
  parameter int TIMEOUT = 48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  issue_rd,
  output logic        stall,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  input  logic        mult_resultRDY,
  input  logic        mult_exception,
  input  logic [31:0] mult_result,
  input  logic        div_resultRDY,
  input  logic        div_exception,
  input  logic [31:0] div_result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  // Counter only ever needs to reach TIMEOUT-1 before WAIT is left.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   op_a_q;
  logic [31:0]   op_b_q;
  logic [4:0]    rd_q;
  logic          is_div_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   wb_data_q;
  logic          wb_exc_q;

  logic          accept;
  logic          div_by_zero;
  logic          sel_rdy;
  logic          sel_exc;
  logic [31:0]   sel_res;
  logic          timeout_hit;

  assign accept      = (state_q == S_IDLE) && issue_valid;
  assign div_by_zero = issue_is_div && (issue_opB == 32'd0);

  // Only the unit that was started is listened to; the other one's ready is noise.
  assign sel_rdy     = is_div_q ? div_resultRDY  : mult_resultRDY;
  assign sel_exc     = is_div_q ? div_exception  : mult_exception;
  assign sel_res     = is_div_q ? div_result     : mult_result;
  assign timeout_hit = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (issue_valid) begin
          // Divide by zero never reaches the divider; it completes immediately.
          state_d = div_by_zero ? S_DONE : S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (sel_rdy || timeout_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand, counter and writeback registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a_q    <= 32'd0;
      op_b_q    <= 32'd0;
      rd_q      <= 5'd0;
      is_div_q  <= 1'b0;
      cnt_q     <= '0;
      wb_data_q <= 32'd0;
      wb_exc_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue_valid) begin
            op_a_q    <= issue_opA;
            op_b_q    <= issue_opB;
            rd_q      <= issue_rd;
            is_div_q  <= issue_is_div;
            wb_data_q <= 32'd0;
            wb_exc_q  <= div_by_zero;
          end
        end
        S_START: begin
          cnt_q <= '0;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // Ready takes priority over a timeout landing in the same cycle.
          if (sel_rdy) begin
            wb_data_q <= sel_res;
            wb_exc_q  <= sel_exc;
          end else if (timeout_hit) begin
            wb_data_q <= 32'd0;
            wb_exc_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    stall        = 1'b0;
    ctrl_MULT    = 1'b0;
    ctrl_DIV     = 1'b0;
    wb_valid     = 1'b0;
    wb_rd        = 5'd0;
    wb_data      = 32'd0;
    wb_exception = 1'b0;
    case (state_q)
      S_IDLE:  stall = issue_valid;
      S_START: begin
        stall     = 1'b1;
        ctrl_DIV  = is_div_q;
        ctrl_MULT = ~is_div_q;
      end
      S_WAIT:  stall = 1'b1;
      S_DONE: begin
        wb_valid     = 1'b1;
        wb_rd        = rd_q;
        wb_data      = wb_data_q;
        wb_exception = wb_exc_q;
      end
      default: ;
    endcase
  end

  assign md_operandA = op_a_q;
  assign md_operandB = op_b_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb/tb_multdiv_issue_ctrl.sv - directed self-checking bench for multdiv_issue_ctrl
module tb_multdiv_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_is_div;
  logic [31:0] issue_opA;
  logic [31:0] issue_opB;
  logic [4:0]  issue_rd;
  logic        stall;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        mult_resultRDY;
  logic        mult_exception;
  logic [31:0] mult_result;
  logic        div_resultRDY;
  logic        div_exception;
  logic [31:0] div_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;

  int checks   = 0;
  int failures = 0;

  // Per-operation event counters, sampled mid-cycle.
  logic mon_clr = 1'b1;
  int   n_div, n_mult, n_stall, n_wbv;

  int lat;

  multdiv_issue_ctrl #(.TIMEOUT(48)) dut (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_is_div   (issue_is_div),
    .issue_opA      (issue_opA),
    .issue_opB      (issue_opB),
    .issue_rd       (issue_rd),
    .stall          (stall),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .md_operandA    (md_operandA),
    .md_operandB    (md_operandB),
    .mult_resultRDY (mult_resultRDY),
    .mult_exception (mult_exception),
    .mult_result    (mult_result),
    .div_resultRDY  (div_resultRDY),
    .div_exception  (div_exception),
    .div_result     (div_result),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_exception   (wb_exception)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mon_clr) begin
      n_div   <= 0;
      n_mult  <= 0;
      n_stall <= 0;
      n_wbv   <= 0;
    end else begin
      n_div   <= n_div   + (ctrl_DIV  ? 1 : 0);
      n_mult  <= n_mult  + (ctrl_MULT ? 1 : 0);
      n_stall <= n_stall + (stall     ? 1 : 0);
      n_wbv   <= n_wbv   + (wb_valid  ? 1 : 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic mon_restart();
    mon_clr = 1'b1;
    @(negedge clock);
    #1;
    mon_clr = 1'b0;
    step();
  endtask

  // Issues one op and runs until wb_valid (or 200 cycles). rdy_at/spur_at are
  // WAIT-cycle numbers (1-based, 0 = never) for the selected / other unit ready.
  // Returns with the bench sitting in the DONE cycle; lat = cycles since accept.
  task automatic do_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dst, input int rdy_at, input logic [31:0] res,
                       input logic exc, input logic start_rdy, input int spur_at,
                       output int lat_o);
    logic sel, oth;
    mon_restart();
    issue_valid  = 1'b1;
    issue_is_div = div;
    issue_opA    = a;
    issue_opB    = b;
    issue_rd     = dst;
    step();
    issue_valid = 1'b0;
    lat_o = 1;
    while (wb_valid !== 1'b1 && lat_o < 200) begin
      sel = (lat_o == 1 && start_rdy) || (rdy_at > 0 && lat_o - 1 == rdy_at);
      oth = (spur_at > 0 && lat_o - 1 == spur_at);
      if (div) begin
        div_resultRDY  = sel;
        div_result     = sel ? res : 32'hDEAD_0000;
        div_exception  = sel & exc;
        mult_resultRDY = oth;
        mult_result    = 32'h0BAD_0BAD;
        mult_exception = oth;
      end else begin
        mult_resultRDY = sel;
        mult_result    = sel ? res : 32'hDEAD_0000;
        mult_exception = sel & exc;
        div_resultRDY  = oth;
        div_result     = 32'h0BAD_0BAD;
        div_exception  = oth;
      end
      step();
      lat_o++;
    end
    mult_resultRDY = 1'b0;
    mult_exception = 1'b0;
    div_resultRDY  = 1'b0;
    div_exception  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    issue_valid    = 1'b0;
    issue_is_div   = 1'b0;
    issue_opA      = 32'd0;
    issue_opB      = 32'd0;
    issue_rd       = 5'd0;
    mult_resultRDY = 1'b0;
    mult_exception = 1'b0;
    mult_result    = 32'd0;
    div_resultRDY  = 1'b0;
    div_exception  = 1'b0;
    div_result     = 32'd0;
    #1;
    check("rst_ctrl", 32'({stall, ctrl_MULT, ctrl_DIV, wb_valid, wb_exception, wb_rd}), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_opA", md_operandA, 32'd0);
    check("rst_opB", md_operandB, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    check("idle_stall", 32'(stall), 32'd0);

    // Divide -100 / 7 = -14, ready in WAIT cycle 34
    do_op(1'b1, -32'sd100, 32'sd7, 5'd5, 34, -32'sd14, 1'b0, 1'b0, 0, lat);
    check("div_lat", 32'(lat), 32'd36);
    check("div_wb_valid", 32'(wb_valid), 32'd1);
    check("div_wb_rd", 32'(wb_rd), 32'd5);
    check("div_wb_data", wb_data, 32'hFFFF_FFF2);
    check("div_wb_exc", 32'(wb_exception), 32'd0);
    check("div_done_stall", 32'(stall), 32'd0);
    check("div_opA_held", md_operandA, 32'hFFFF_FF9C);
    step();
    check("div_wb_one_cycle", 32'(wb_valid), 32'd0);
    check("div_n_ctrl_div", 32'(n_div), 32'd1);
    check("div_n_ctrl_mult", 32'(n_mult), 32'd0);
    check("div_n_stall", 32'(n_stall), 32'd36);
    check("div_n_wbv", 32'(n_wbv), 32'd1);

    // Divide by zero completes one cycle after accept without a strobe
    do_op(1'b1, 32'd9, 32'd0, 5'd3, 0, 32'd0, 1'b0, 1'b0, 0, lat);
    check("dz_lat", 32'(lat), 32'd1);
    check("dz_wb_rd", 32'(wb_rd), 32'd3);
    check("dz_wb_data", wb_data, 32'd0);
    check("dz_wb_exc", 32'(wb_exception), 32'd1);
    step();
    check("dz_n_ctrl", 32'(n_div + n_mult), 32'd0);
    check("dz_n_stall", 32'(n_stall), 32'd1);

    // Multiply 3 * -4, rd=0; ready in START and spurious div ready both ignored
    do_op(1'b0, 32'd3, -32'sd4, 5'd0, 5, -32'sd12, 1'b0, 1'b1, 2, lat);
    check("mul_lat", 32'(lat), 32'd7);
    check("mul_wb_valid", 32'(wb_valid), 32'd1);
    check("mul_wb_rd", 32'(wb_rd), 32'd0);
    check("mul_wb_data", wb_data, 32'hFFFF_FFF4);
    check("mul_wb_exc", 32'(wb_exception), 32'd0);
    check("mul_opB_held", md_operandB, 32'hFFFF_FFFC);
    step();
    check("mul_n_ctrl_mult", 32'(n_mult), 32'd1);
    check("mul_n_ctrl_div", 32'(n_div), 32'd0);

    // Unit exception propagates from the first WAIT cycle
    do_op(1'b0, 32'd7, 32'd8, 5'd9, 1, 32'h0000_0007, 1'b1, 1'b0, 0, lat);
    check("mexc_lat", 32'(lat), 32'd3);
    check("mexc_wb_data", wb_data, 32'h0000_0007);
    check("mexc_wb_exc", 32'(wb_exception), 32'd1);
    step();

    // Timeout: no ready ever, 48 WAIT cycles
    do_op(1'b1, 32'd1, 32'd2, 5'd12, 0, 32'd0, 1'b0, 1'b0, 0, lat);
    check("to_lat", 32'(lat), 32'd50);
    check("to_wb_rd", 32'(wb_rd), 32'd12);
    check("to_wb_data", wb_data, 32'd0);
    check("to_wb_exc", 32'(wb_exception), 32'd1);
    step();
    check("to_n_wbv", 32'(n_wbv), 32'd1);

    // Ready on the timeout cycle wins
    do_op(1'b1, 32'd1, 32'd2, 5'd13, 48, 32'h0000_ABCD, 1'b0, 1'b0, 0, lat);
    check("race_lat", 32'(lat), 32'd50);
    check("race_wb_data", wb_data, 32'h0000_ABCD);
    check("race_wb_exc", 32'(wb_exception), 32'd0);
    step();

    // Reset during the 10th WAIT cycle aborts the operation
    mon_restart();
    issue_valid  = 1'b1;
    issue_is_div = 1'b1;
    issue_opA    = 32'd50;
    issue_opB    = 32'd3;
    issue_rd     = 5'd7;
    step();
    issue_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("abort_pre_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_ctrl", 32'({stall, ctrl_MULT, ctrl_DIV, wb_valid, wb_exception, wb_rd}), 32'd0);
    check("abort_wb_data", wb_data, 32'd0);
    check("abort_opA", md_operandA, 32'd0);
    check("abort_opB", md_operandB, 32'd0);
    step();
    reset = 1'b0;
    mon_restart();
    div_resultRDY = 1'b1;
    div_result    = 32'h0000_0077;
    step();
    step();
    div_resultRDY = 1'b0;
    step();
    step();
    check("abort_n_wbv", 32'(n_wbv), 32'd0);
    check("abort_n_stall", 32'(n_stall), 32'd0);

    // Back-to-back with issue_valid held: accept, START, WAIT, DONE, accept, ...
    mon_restart();
    issue_valid   = 1'b1;
    issue_is_div  = 1'b1;
    issue_opA     = 32'd20;
    issue_opB     = 32'd5;
    issue_rd      = 5'd4;
    div_resultRDY = 1'b1;
    div_result    = 32'd4;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 3) begin
        check("b2b_done1", 32'(wb_valid), 32'd1);
        check("b2b_done1_stall", 32'(stall), 32'd0);
      end
      if (i == 4) check("b2b_reaccept_stall", 32'({stall, wb_valid}), 32'b10);
      if (i == 5) check("b2b_start2", 32'(ctrl_DIV), 32'd1);
      if (i == 7) check("b2b_done2", 32'({wb_valid, wb_rd}), 32'b1_00100);
    end
    issue_valid   = 1'b0;
    div_resultRDY = 1'b0;
    step();
    step();
    check("b2b_n_wbv", 32'(n_wbv), 32'd2);
    check("b2b_n_div", 32'(n_div), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_issue_ctrl.md
MULTDIV_ISSUE_CTRL -- requirements
Module: multdiv_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 48: max WAIT cycles before the operation is forced to complete with an exception.
REQ-002 clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 issue_valid  in  1  execute stage presents a mult/div instruction.
REQ-005 issue_is_div  in  1  1 = divide, 0 = multiply.
REQ-006 issue_opA, issue_opB  in  32 each  signed operands.
REQ-007 issue_rd  in  5  destination register.
REQ-008 stall  out  1  freezes the upstream pipeline.
REQ-009 ctrl_MULT, ctrl_DIV  out  1 each  start pulses to the multiplier/divider units.
REQ-010 md_operandA, md_operandB  out  32 each  latched operands, held stable from START through DONE.
REQ-011 mult_resultRDY, mult_exception  in  1 each; mult_result  in  32  multiplier outputs.
REQ-012 div_resultRDY, div_exception  in  1 each; div_result  in  32  divider outputs.
REQ-013 wb_valid  out  1; wb_rd  out  5; wb_data  out  32; wb_exception  out  1  writeback, valid for one cycle.

Function
REQ-014 The FSM SHALL have states IDLE, START, WAIT, DONE and SHALL reset to IDLE.
REQ-015 issue_valid SHALL be sampled only in IDLE; in IDLE with issue_valid=1 it SHALL latch opA, opB, rd and is_div, then go to START.
REQ-016 An accepted divide with issue_opB==0 SHALL go directly from IDLE to DONE: no ctrl pulse, wb_data=0, wb_exception=1.
REQ-017 stall SHALL equal (IDLE & issue_valid) | START | WAIT, combinationally; stall SHALL be 0 in DONE.
REQ-018 In START, exactly one of ctrl_DIV/ctrl_MULT (per latched is_div) SHALL be 1, for exactly that one cycle.
REQ-019 START SHALL clear the timeout counter and go to WAIT unconditionally.
REQ-020 Any resultRDY arriving in the START cycle SHALL be ignored.
REQ-021 In WAIT, the counter SHALL increment once per cycle.
REQ-022 In WAIT, the selected unit's resultRDY=1 SHALL capture that unit's result and exception into the wb registers and go to DONE.
REQ-023 The non-selected unit's resultRDY SHALL be ignored.
REQ-024 In WAIT, counter==TIMEOUT-1 with no selected RDY SHALL go to DONE with wb_data=0, wb_exception=1.
REQ-025 If the selected RDY coincides with the timeout cycle, the RDY SHALL win.
REQ-026 In DONE, wb_valid=1 and wb_rd=latched rd (including rd=0) for one cycle; next state SHALL be IDLE.
REQ-027 issue_valid asserted during DONE is the completing instruction and SHALL NOT start a new operation.
REQ-028 Back-to-back operations SHALL resume with a new accept in the IDLE cycle after DONE.
REQ-029 Latency from accept to wb_valid SHALL be N+2 cycles, where N is the number of WAIT cycles up to and including the RDY cycle.

Reset
REQ-030 Reset SHALL force: state=IDLE, counter=0, stall=0, ctrl_MULT=ctrl_DIV=0, wb_valid=0, wb_exception=0, and wb_rd, wb_data, md_operandA, md_operandB all 0.
REQ-031 Reset asserted mid-operation (START/WAIT/DONE) SHALL abort with no wb_valid pulse; RDY pulses after reset release SHALL be ignored while in IDLE.

Verification
REQ-032 Divide: opA=-100, opB=7, rd=5; div_resultRDY after 34 WAIT cycles with div_result=-14 -> single ctrl_DIV pulse, stall high 36 cycles, wb_valid one cycle with wb_rd=5, wb_data=0xFFFFFFF2, wb_exception=0.
REQ-033 Divide by zero: opA=9, opB=0 -> no ctrl_DIV, DONE one cycle after accept, wb_data=0, wb_exception=1.
REQ-034 Multiply: opA=3, opB=-4 -> ctrl_MULT pulse only; a spurious div_resultRDY in WAIT is ignored; mult_result=-12 -> wb_data=0xFFFFFFF4.
REQ-035 Timeout: TIMEOUT=48, RDY never asserted -> wb_valid exactly 48 WAIT cycles after START, wb_exception=1, wb_data=0.
REQ-036 Reset in the 10th WAIT cycle -> all outputs 0 asynchronously; a later div_resultRDY produces no wb_valid.
REQ-037 Back-to-back ops with issue_valid held high -> second accept in the IDLE cycle after DONE; exactly two wb_valid pulses.
